// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, default 640x480 timing and colour-bar table
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_PASS  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_WHITE = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 29;

  // {r,g,b} on/off per bar, index 0 = leftmost (white) .. 7 = black
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - combinational colour source select (renderer or test pattern)
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W  = 4,
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640
) (
  input  logic [CW-1:0]        i_x,
  input  pattern_e             i_pattern,
  input  logic [3*COLOR_W-1:0] i_rgb,
  output logic [3*COLOR_W-1:0] o_rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] w_bar;
  logic [2:0] w_bar_rgb;

  assign w_bar     = 3'(i_x / CW'(BAR_W));
  assign w_bar_rgb = BAR_TABLE[w_bar];

  always_comb begin
    o_rgb = '0;
    case (i_pattern)
      PAT_PASS:  o_rgb = i_rgb;
      PAT_BARS:  o_rgb = {{COLOR_W{w_bar_rgb[2]}}, {COLOR_W{w_bar_rgb[1]}}, {COLOR_W{w_bar_rgb[0]}}};
      PAT_WHITE: o_rgb = '1;
      default:   o_rgb = '0;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster engine with aligned sync/colour pipeline
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 4,
  localparam int  H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP,
  localparam int  V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP,
  localparam int  CW       = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
  input  logic                 dclk,
  input  logic                 clr_n,
  input  logic                 ce,
  input  logic [1:0]           pattern_sel,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic [CW-1:0]        x,
  output logic [CW-1:0]        y,
  output logic                 de,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 hsync,
  output logic                 vsync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [CW-1:0]        r_hc, r_vc;
  logic [CW-1:0]        r_x, r_y;
  logic                 r_de, r_line_start, r_frame_start, r_hs_act, r_vs_act;
  logic                 r_hsync, r_vsync;
  logic [COLOR_W-1:0]   r_red, r_green, r_blue;
  pattern_e             r_pattern;

  logic                 w_de;
  logic [CW-1:0]        w_x, w_y;
  logic [3*COLOR_W-1:0] w_rgb;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_hc      <= '0;
      r_vc      <= '0;
      r_pattern <= PAT_PASS;
    end else if (ce) begin
      // Pattern only switches at the top of a frame so a frame is never mixed
      if (r_hc == '0 && r_vc == '0)
        r_pattern <= pattern_e'(pattern_sel);
      if (r_hc == CW'(H_TOTAL - 1)) begin
        r_hc <= '0;
        r_vc <= (r_vc == CW'(V_TOTAL - 1)) ? '0 : r_vc + CW'(1);
      end else begin
        r_hc <= r_hc + CW'(1);
      end
    end
  end

  assign w_de = (r_hc >= CW'(H_ACT_START)) && (r_hc < CW'(H_ACT_END)) &&
                (r_vc >= CW'(V_ACT_START)) && (r_vc < CW'(V_ACT_END));
  assign w_x  = r_hc - CW'(H_ACT_START);
  assign w_y  = r_vc - CW'(V_ACT_START);

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs_act      <= 1'b0;
      r_vs_act      <= 1'b0;
    end else if (ce) begin
      r_de          <= w_de;
      r_x           <= w_de ? w_x : '0;
      r_y           <= w_de ? w_y : '0;
      r_line_start  <= w_de && (w_x == '0);
      r_frame_start <= w_de && (w_x == '0) && (w_y == '0);
      r_hs_act      <= r_hc < CW'(H_SYNC);
      r_vs_act      <= r_vc < CW'(V_SYNC);
    end
  end

  vga_pattern_gen #(
    .COLOR_W  (COLOR_W),
    .CW       (CW),
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .i_x       (r_x),
    .i_pattern (r_pattern),
    .i_rgb     (rgb_in),
    .o_rgb     (w_rgb)
  );

  // Stage 2: syncs and colour leave together so the DAC sees them aligned
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (ce) begin
      r_hsync <= r_hs_act ? HS_POL : ~HS_POL;
      r_vsync <= r_vs_act ? VS_POL : ~VS_POL;
      r_red   <= r_de ? w_rgb[3*COLOR_W-1 -: COLOR_W] : '0;
      r_green <= r_de ? w_rgb[2*COLOR_W-1 -: COLOR_W] : '0;
      r_blue  <= r_de ? w_rgb[COLOR_W-1 -: COLOR_W]   : '0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench on a reduced 16x4 raster
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACTIVE = 4,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int CW = 5;

  logic        dclk = 1'b0;
  logic        clr_n = 1'b0;
  logic        ce = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] rgb_in;
  logic [CW-1:0] x, y;
  logic        de, line_start, frame_start, hsync, vsync;
  logic [3:0]  red, green, blue;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  always #5 dclk = ~dclk;

  // Renderer stand-in: colour encodes the coordinate it was asked for
  assign rgb_in = {x[3:0], y[3:0], 4'h5};

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (1'b0),     .VS_POL (1'b1), .COLOR_W (4)
  ) dut (
    .dclk        (dclk),
    .clr_n       (clr_n),
    .ce          (ce),
    .pattern_sel (pattern_sel),
    .rgb_in      (rgb_in),
    .x           (x),
    .y           (y),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  typedef struct {
    int         t;
    logic [1:0] sel;
    logic       de;
    int         x, y;
    logic       ls, fs, hs, vs;
    int         r, g, b;
  } vec_t;

  vec_t vec[26];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
    t++;
  endtask

  task automatic do_reset(input logic [1:0] sel);
    ce = 1'b0;
    clr_n = 1'b0;
    pattern_sel = sel;
    @(posedge dclk);
    #3;
    clr_n = 1'b1;
    t = 0;
    ce = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_ls"}, int'(line_start), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_hs"}, int'(hsync), 1);
    check({tag, "_vs"}, int'(vsync), 0);
    check({tag, "_rgb"}, int'({red, green, blue}), 0);
  endtask

  initial begin
    int cur_sel;
    int cnt, rise, width;
    int hs_lo, vs_hi, de_n, fs_n, ls_n;

    //        t    sel de  x   y  ls fs hs vs  r    g    b
    vec[0]  = '{1,   0, 0,  0,  0, 0, 0, 1, 0, 0,   0,   0};
    vec[1]  = '{2,   0, 0,  0,  0, 0, 0, 0, 1, 0,   0,   0};
    vec[2]  = '{5,   0, 0,  0,  0, 0, 0, 1, 1, 0,   0,   0};
    vec[3]  = '{47,  0, 0,  0,  0, 0, 0, 1, 1, 0,   0,   0};
    vec[4]  = '{48,  0, 0,  0,  0, 0, 0, 0, 0, 0,   0,   0};
    vec[5]  = '{75,  0, 1,  0,  0, 1, 1, 1, 0, 0,   0,   0};
    vec[6]  = '{76,  0, 1,  1,  0, 0, 0, 1, 0, 0,   0,   5};
    vec[7]  = '{77,  0, 1,  2,  0, 0, 0, 1, 0, 1,   0,   5};
    vec[8]  = '{91,  0, 0,  0,  0, 0, 0, 1, 0, 15,  0,   5};
    vec[9]  = '{92,  0, 0,  0,  0, 0, 0, 1, 0, 0,   0,   0};
    vec[10] = '{98,  0, 1,  0,  1, 1, 0, 1, 0, 0,   0,   0};
    vec[11] = '{99,  0, 1,  1,  1, 0, 0, 1, 0, 0,   1,   5};
    vec[12] = '{144, 0, 1,  0,  3, 1, 0, 1, 0, 0,   0,   0};
    vec[13] = '{167, 0, 0,  0,  0, 0, 0, 1, 0, 0,   0,   0};
    vec[14] = '{186, 0, 0,  0,  0, 0, 0, 0, 1, 0,   0,   0};
    vec[15] = '{259, 0, 1,  0,  0, 1, 1, 1, 0, 0,   0,   0};
    vec[16] = '{75,  1, 1,  0,  0, 1, 1, 1, 0, 0,   0,   0};
    vec[17] = '{76,  1, 1,  1,  0, 0, 0, 1, 0, 15,  15,  15};
    vec[18] = '{77,  1, 1,  2,  0, 0, 0, 1, 0, 15,  15,  15};
    vec[19] = '{78,  1, 1,  3,  0, 0, 0, 1, 0, 15,  15,  0};
    vec[20] = '{80,  1, 1,  5,  0, 0, 0, 1, 0, 0,   15,  15};
    vec[21] = '{86,  1, 1,  11, 0, 0, 0, 1, 0, 15,  0,   0};
    vec[22] = '{88,  1, 1,  13, 0, 0, 0, 1, 0, 0,   0,   15};
    vec[23] = '{89,  1, 1,  14, 0, 0, 0, 1, 0, 0,   0,   15};
    vec[24] = '{90,  1, 1,  15, 0, 0, 0, 1, 0, 0,   0,   0};
    vec[25] = '{92,  1, 0,  0,  0, 0, 0, 1, 0, 0,   0,   0};

    repeat (2) @(posedge dclk);
    #1;
    check_reset_outputs("reset");

    cur_sel = -1;
    foreach (vec[i]) begin
      if (int'(vec[i].sel) != cur_sel || vec[i].t < t) begin
        do_reset(vec[i].sel);
        cur_sel = int'(vec[i].sel);
      end
      while (t < vec[i].t) tick();
      check($sformatf("v%0d_de", i), int'(de), int'(vec[i].de));
      check($sformatf("v%0d_x", i), int'(x), vec[i].x);
      check($sformatf("v%0d_y", i), int'(y), vec[i].y);
      check($sformatf("v%0d_ls", i), int'(line_start), int'(vec[i].ls));
      check($sformatf("v%0d_fs", i), int'(frame_start), int'(vec[i].fs));
      check($sformatf("v%0d_hs", i), int'(hsync), int'(vec[i].hs));
      check($sformatf("v%0d_vs", i), int'(vsync), int'(vec[i].vs));
      check($sformatf("v%0d_r", i), int'(red), vec[i].r);
      check($sformatf("v%0d_g", i), int'(green), vec[i].g);
      check($sformatf("v%0d_b", i), int'(blue), vec[i].b);
    end

    // Two full frames: per-frame sync/de/pulse counts
    do_reset(2'd0);
    while (t < 2) tick();
    hs_lo = 0; vs_hi = 0; de_n = 0; fs_n = 0; ls_n = 0;
    repeat (368) begin
      tick();
      hs_lo += int'(!hsync);
      vs_hi += int'(vsync);
      de_n  += int'(de);
      fs_n  += int'(frame_start);
      ls_n  += int'(line_start);
    end
    check("cnt_hsync_active", hs_lo, 48);
    check("cnt_vsync_active", vs_hi, 92);
    check("cnt_de", de_n, 128);
    check("cnt_frame_start", fs_n, 2);
    check("cnt_line_start", ls_n, 8);

    // pattern_sel change mid-frame takes effect only at the next frame
    do_reset(2'd0);
    while (t < 100) tick();
    pattern_sel = 2'd2;
    while (t < 122) tick();
    check("midsw_keep_rgb", int'({red, green, blue}), 12'h025);
    while (t < 160) tick();
    check("midsw_last_rgb", int'({red, green, blue}), 12'hF35);
    while (t < 259) tick();
    check("midsw_blank_rgb", int'({red, green, blue}), 12'h000);
    tick();
    check("midsw_white_rgb", int'({red, green, blue}), 12'hFFF);

    // ce alternating: frame_start arrives on the 75th ce and holds through the gap
    do_reset(2'd0);
    rise = -1; width = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      ce = cyc[0];
      @(posedge dclk);
      #1;
      if (frame_start) begin
        if (rise < 0) rise = cyc;
        if (rise >= 0 && cyc < rise + 10) width++;
      end
    end
    ce = 1'b1;
    check("ce_half_fs_rise", rise, 149);
    check("ce_half_fs_width", width, 2);

    // Async reset mid-line, then exact restart latency to frame_start
    do_reset(2'd0);
    while (t < 78) tick();
    check("pre_rst_de", int'(de), 1);
    #2;
    clr_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #1;
    clr_n = 1'b1;
    cnt = 0;
    while (!frame_start && cnt < 300) begin
      @(posedge dclk);
      #1;
      cnt++;
    end
    check("restart_fs_latency", cnt, (V_SYNC + V_BP) * (H_SYNC + H_BP + H_ACTIVE + H_FP) + H_SYNC + H_BP + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised VGA raster engine; successor to the fixed 640x480 generator.
- All horizontal/vertical timing, sync polarity and colour depth are parameters.
- Exports pixel coordinates and a data-enable to an upstream renderer, then returns renderer colour (or a built-in test pattern) to the DAC pins, pipelined so that sync and colour stay aligned.
- Sits between the pixel-clock domain root and the board VGA connector.

## Interface
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 29, vertical back porch
- HS_POL, 0, hsync active level; VS_POL, 0, vsync active level
- COLOR_W, 4, bits per colour channel
- dclk  in  1  pixel clock
- clr_n  in  1  asynchronous, active-low reset
- ce  in  1  pixel enable; all state advances only when high
- pattern_sel  in  2  0 renderer pass-through, 1 colour bars, 2 solid white, 3 black
- rgb_in  in  3*COLOR_W  renderer colour {r,g,b} for the current x/y
- x, y  out  CW each  active-area coordinate, CW = $clog2(max(H_TOTAL,V_TOTAL))
- de  out  1  x/y lie inside the active area
- line_start  out  1  one-ce pulse on the first active pixel of each active line
- frame_start  out  1  one-ce pulse on pixel (0,0)
- hsync, vsync  out  1  VGA syncs, registered
- red, green, blue  out  COLOR_W each  registered colour

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 800); V_TOTAL likewise (default 521).
- Line order: sync, back porch, active, front porch. Frame order is the same.
- Stage 0 counters:
  - hc counts 0..H_TOTAL-1 per ce and wraps to 0.
  - On the hc wrap, vc increments and wraps 0..V_TOTAL-1.
- Stage 1 registers from hc/vc:
  - de = hc in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vc in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x = hc-(H_SYNC+H_BP) and y = vc-(V_SYNC+V_BP) when de, else 0.
  - Sync active when hc<H_SYNC (resp. vc<V_SYNC).
  - line_start = de && x==0; frame_start = de && x==0 && y==0.
- Stage 2 registers red/green/blue, hsync, vsync:
  - Syncs are delayed copies of the stage-1 syncs, driven at the HS_POL/VS_POL level when active.
  - Colour forced to 0 whenever the stage-1 de is 0.
- Pattern source:
  - pattern_sel is latched into an internal register only when hc==0 && vc==0 && ce, so the source never changes mid-frame.
  - Pass-through: rgb_in sampled combinationally against the stage-1 x/y; the renderer must be combinational or pre-fetch.
  - Colour bars: bar = x / (H_ACTIVE/8). Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or zero.

## Timing
- Reset (clr_n low, async):
  - hc=vc=0; x=y=0; de, line_start, frame_start = 0.
  - Syncs at the inactive level; colour 0; latched pattern = 0.
- Release: the first ce after release advances hc from 0 to 1. Stage-1 outputs reflect counter value N one ce later; pins reflect it two ce later.
- ce low: every register holds, including pulses. A pulse therefore stays high until the next ce and counts as one pixel.
- Wrap: hc=H_TOTAL-1 and vc=V_TOTAL-1 on the same ce gives hc=0, vc=0.
- Reset mid-line: immediate return to reset values; restart at sync region of line 0.

## Structure
- Package vga_pkg holds:
  - pattern_e enum (PAT_PASS, PAT_BARS, PAT_WHITE, PAT_BLACK);
  - default 640x480 timing constants;
  - the 8-entry bar colour table.
- Sub-module vga_pattern_gen: combinational; inputs x, latched pattern, rgb_in; output selected colour.

## Test plan
- Defaults, ce=1, 2 frames: hsync low exactly 96 of every 800 cycles, vsync low 2 of 521 lines, de count per frame = 307200, frame_start once per 416800 cycles.
- Alignment: renderer returns {x[3:0],y[3:0],4'h5} in pass-through. At the pin, the first active pixel of line 0 shows red=0, green=0, blue=5; hsync and colour edges stay offset by H_SYNC+H_BP.
- pattern_sel=1: pixel x=79 gives white (F,F,F), x=80 yellow (F,F,0), x=639 black. Blanking is 0 everywhere.
- Change pattern_sel from 0 to 2 at mid-frame line 100: output unchanged until frame_start, then all active pixels read (F,F,F).
- ce toggled 1/0 every cycle: waveform identical to the ce=1 case stretched ×2, and line_start is 2 cycles wide.
- clr_n pulsed low at hc=400, vc=200: all outputs reset immediately. After release, the first frame_start arrives after exactly (V_SYNC+V_BP)*H_TOTAL+H_SYNC+H_BP+1 ce.
